// File: rtl/uart_frame_generator.sv
// Queued UART transmitter: start bit, LSB-first data, optional parity, 1/2 stop bits, idle gap.
// Define UART_FRAME_GENERATOR_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module uart_frame_generator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic                                 UART_clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 data_valid,
    output logic                                 data_ready,
    input  logic                                 parity_enable,
    input  logic                                 parity_type,
    input  logic                                 two_stop_bits,
    output logic                                 serial_data_out,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

`ifdef UART_FRAME_GENERATOR_FIFO_EN
    localparam int unsigned DEPTH = FIFO_DEPTH;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TMR_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    // Queue storage and pointers
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;

    // Frame state
    state_t                state;
    logic [TMR_W-1:0]      tmr;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  par_en_r;
    logic                  two_stop_r;

    logic bit_end;
    logic gap_end;
    logic last_data;
    logic final_stop;
    logic frame_end;
    logic next_final_stop;
    logic next_last_tick;
    logic done_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = data_valid & data_ready;

    assign bit_end    = (tmr == TMR_W'(PRESCALE - 1));
    assign gap_end    = (tmr == TMR_W'(GAP_CYCLES - 1));
    assign last_data  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign final_stop = (state == STOP) && (stop_idx == two_stop_r);
    assign frame_end  = final_stop && bit_end;

    // frame_done is registered, so predict whether the coming cycle is the last tick of the final stop bit
    assign next_final_stop = bit_end
        ? ((state == DATA && last_data && !par_en_r && !two_stop_r) ||
           (state == PARITY && !two_stop_r) ||
           (state == STOP && !stop_idx && two_stop_r))
        : final_stop;
    assign next_last_tick = bit_end ? (PRESCALE == 1) : (tmr == TMR_W'(PRESCALE - 2));
    assign done_next      = next_final_stop && next_last_tick;

    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) ||
                  (state == GAP && gap_end) ||
                  (frame_end && (GAP_CYCLES == 0)));

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    // Queue data array (no reset needed: occupancy is tracked by fifo_count)
    always_ff @(posedge UART_clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge UART_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count <= count_next;
            data_ready <= (count_next != CNT_W'(DEPTH));
        end
    end

    // Frame FSM with registered line, busy and frame_done
    always_ff @(posedge UART_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            tmr             <= '0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            shreg           <= '0;
            par_bit         <= 1'b0;
            par_en_r        <= 1'b0;
            two_stop_r      <= 1'b0;
            serial_data_out <= 1'b1;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= done_next;
            if (pop) begin
                // Frame configuration is latched here and held for the whole frame
                state           <= START;
                tmr             <= '0;
                shreg           <= mem[rd_ptr];
                par_bit         <= (^mem[rd_ptr]) ^ parity_type;
                par_en_r        <= parity_enable;
                two_stop_r      <= two_stop_bits;
                serial_data_out <= 1'b0;
                busy            <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        serial_data_out <= 1'b1;
                        busy            <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state           <= DATA;
                            tmr             <= '0;
                            bit_idx         <= '0;
                            serial_data_out <= shreg[0];
                            shreg           <= shreg >> 1;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            tmr <= '0;
                            if (!last_data) begin
                                bit_idx         <= bit_idx + IDX_W'(1);
                                serial_data_out <= shreg[0];
                                shreg           <= shreg >> 1;
                            end else if (par_en_r) begin
                                state           <= PARITY;
                                serial_data_out <= par_bit;
                            end else begin
                                state           <= STOP;
                                stop_idx        <= 1'b0;
                                serial_data_out <= 1'b1;
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state           <= STOP;
                            tmr             <= '0;
                            stop_idx        <= 1'b0;
                            serial_data_out <= 1'b1;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            tmr <= '0;
                            if (!final_stop) begin
                                stop_idx <= 1'b1;
                            end else if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            state <= IDLE;
                            tmr   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    default: begin
                        state           <= IDLE;
                        serial_data_out <= 1'b1;
                        busy            <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_frame_generator.md
UART_FRAME_GENERATOR -- requirements
Module: uart_frame_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PRESCALE, default 8, meaning UART_clk cycles per serial bit, minimum 1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning queued frames, power of 2, minimum 2.
REQ-004 SHALL have parameter GAP_CYCLES, default 3, meaning idle-high UART_clk cycles inserted after every stop bit, minimum 0.
REQ-005 SHALL have port UART_clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits: word to queue.
REQ-008 SHALL have port data_valid, input, 1 bit: push request.
REQ-009 SHALL have port data_ready, output, 1 bit: queue not full.
REQ-010 SHALL have port parity_enable, input, 1 bit: parity bit present.
REQ-011 SHALL have port parity_type, input, 1 bit: 0 even, 1 odd.
REQ-012 SHALL have port two_stop_bits, input, 1 bit: 0 one stop bit, 1 two stop bits.
REQ-013 SHALL have port serial_data_out, output, 1 bit: serial line, idle high.
REQ-014 SHALL have port busy, output, 1 bit: high from frame start through end of gap.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of last stop bit.
REQ-016 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1) bits: queued-word count.

Function
REQ-017 SHALL push data_in on a rising edge with data_valid=1 and data_ready=1; a push while data_ready=0 SHALL be dropped silently.
REQ-018 SHALL use an FSM with states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-019 In IDLE with a non-empty queue, the FSM SHALL pop one word on the next edge and enter START; serial_data_out SHALL be registered low from that edge.
REQ-020 Latency from a push into an empty idle queue to serial_data_out falling SHALL be exactly 2 edges.
REQ-021 SHALL sample parity_enable, parity_type and two_stop_bits at the pop edge; changes mid-frame SHALL NOT affect the current frame.
REQ-022 SHALL hold each bit for exactly PRESCALE cycles, in this order:
- start bit (0)
- DATA_WIDTH data bits, LSB first
- parity bit, if enabled: XOR of the data bits XOR parity_type
- 1 or 2 stop bits (1)
REQ-023 SHALL pulse frame_done in the last cycle of the final stop bit, then hold the line high for GAP_CYCLES cycles in GAP; with GAP_CYCLES=0, GAP SHALL be skipped.
REQ-024 From GAP end with a non-empty queue, SHALL start the next frame back-to-back per REQ-019; otherwise SHALL return to IDLE.
REQ-025 busy SHALL be high in START, DATA, PARITY, STOP and GAP, and low in IDLE.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged and lose no data.
REQ-027 Queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 data_ready SHALL be 0 exactly when fifo_count equals the queue capacity.

Reset
REQ-029 Asserting reset SHALL immediately, without a clock:
- force serial_data_out=1, busy=0, frame_done=0
- set fifo_count=0 and data_ready=1
- put the FSM in IDLE and discard all queued words
REQ-030 Reset mid-frame SHALL abort the frame with no partial retransmission after release.
REQ-031 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-032 With macro UART_FRAME_GENERATOR_FIFO_EN defined, the queue SHALL be FIFO_DEPTH entries deep.
REQ-033 Without UART_FRAME_GENERATOR_FIFO_EN:
- FIFO_DEPTH SHALL be ignored and the queue SHALL be a single holding register (capacity 1)
- fifo_count SHALL read only 0 or 1
- all other behaviour SHALL be unchanged

Verification
REQ-034 Push 0xA5, parity_enable=1, parity_type=0, one stop, PRESCALE=8 -> line carries 0,1,0,1,0,0,1,0,1,0,1 with each bit 8 cycles (88 total); frame_done at cycle 88.
REQ-035 Same as REQ-034 with parity_type=1 -> parity bit 1; with parity_enable=0, two_stop_bits=1 -> 11 bits (0,10100101 LSB-first,1,1), 88 cycles.
REQ-036 FIFO_EN, depth 4, push 5 words on consecutive edges -> word 1 popped first, words 2-5 fill the queue, data_ready=0 once 4 are queued, a 6th push is dropped, and 5 frames go out separated by exactly 3 idle-high cycles each.
REQ-037 Assert reset at cycle 40 of a frame -> line high within the same time step, fifo_count=0, no further frames after release.
REQ-038 Push while the last queued word pops (count 1) -> count stays 1 and both words transmit in order.
REQ-039 Change parity_type mid-frame -> the current frame's parity follows the value sampled at the pop edge; the next frame uses the new value.
